// File: rtl/apb_gpio_core.sv
// rtl/apb_gpio_core.sv - APB slave GPIO controller with per-bit configuration and interrupts
// Ports:
//   PCLK, PRESETN                  clock and asynchronous active-low reset
//   PSEL, PENABLE, PWRITE, PADDR,
//   PWDATA, PRDATA, PREADY, PSLVERR APB slave (zero wait states, never errors)
//   GPIO_IN                        asynchronous pad inputs
//   GPIO_OUT, GPIO_OE              pad output values and output enables
//   INT, INT_OR                    per-bit interrupt flags and their OR
module apb_gpio_core #(
   parameter int                IO_NUM    = 32,
   parameter int                APB_WIDTH = 32,
   parameter int                OE_TYPE   = 0,
   parameter int                INT_BUS   = 0,
   parameter logic [IO_NUM-1:0] IO_VAL    = '0,
   parameter bit FIXED_CONFIG_0  = 1'b0, parameter bit FIXED_CONFIG_1  = 1'b0,
   parameter bit FIXED_CONFIG_2  = 1'b0, parameter bit FIXED_CONFIG_3  = 1'b0,
   parameter bit FIXED_CONFIG_4  = 1'b0, parameter bit FIXED_CONFIG_5  = 1'b0,
   parameter bit FIXED_CONFIG_6  = 1'b0, parameter bit FIXED_CONFIG_7  = 1'b0,
   parameter bit FIXED_CONFIG_8  = 1'b0, parameter bit FIXED_CONFIG_9  = 1'b0,
   parameter bit FIXED_CONFIG_10 = 1'b0, parameter bit FIXED_CONFIG_11 = 1'b0,
   parameter bit FIXED_CONFIG_12 = 1'b0, parameter bit FIXED_CONFIG_13 = 1'b0,
   parameter bit FIXED_CONFIG_14 = 1'b0, parameter bit FIXED_CONFIG_15 = 1'b0,
   parameter bit FIXED_CONFIG_16 = 1'b0, parameter bit FIXED_CONFIG_17 = 1'b0,
   parameter bit FIXED_CONFIG_18 = 1'b0, parameter bit FIXED_CONFIG_19 = 1'b0,
   parameter bit FIXED_CONFIG_20 = 1'b0, parameter bit FIXED_CONFIG_21 = 1'b0,
   parameter bit FIXED_CONFIG_22 = 1'b0, parameter bit FIXED_CONFIG_23 = 1'b0,
   parameter bit FIXED_CONFIG_24 = 1'b0, parameter bit FIXED_CONFIG_25 = 1'b0,
   parameter bit FIXED_CONFIG_26 = 1'b0, parameter bit FIXED_CONFIG_27 = 1'b0,
   parameter bit FIXED_CONFIG_28 = 1'b0, parameter bit FIXED_CONFIG_29 = 1'b0,
   parameter bit FIXED_CONFIG_30 = 1'b0, parameter bit FIXED_CONFIG_31 = 1'b0,
   parameter logic [1:0] IO_TYPE_0  = 2'd0, parameter logic [1:0] IO_TYPE_1  = 2'd0,
   parameter logic [1:0] IO_TYPE_2  = 2'd0, parameter logic [1:0] IO_TYPE_3  = 2'd0,
   parameter logic [1:0] IO_TYPE_4  = 2'd0, parameter logic [1:0] IO_TYPE_5  = 2'd0,
   parameter logic [1:0] IO_TYPE_6  = 2'd0, parameter logic [1:0] IO_TYPE_7  = 2'd0,
   parameter logic [1:0] IO_TYPE_8  = 2'd0, parameter logic [1:0] IO_TYPE_9  = 2'd0,
   parameter logic [1:0] IO_TYPE_10 = 2'd0, parameter logic [1:0] IO_TYPE_11 = 2'd0,
   parameter logic [1:0] IO_TYPE_12 = 2'd0, parameter logic [1:0] IO_TYPE_13 = 2'd0,
   parameter logic [1:0] IO_TYPE_14 = 2'd0, parameter logic [1:0] IO_TYPE_15 = 2'd0,
   parameter logic [1:0] IO_TYPE_16 = 2'd0, parameter logic [1:0] IO_TYPE_17 = 2'd0,
   parameter logic [1:0] IO_TYPE_18 = 2'd0, parameter logic [1:0] IO_TYPE_19 = 2'd0,
   parameter logic [1:0] IO_TYPE_20 = 2'd0, parameter logic [1:0] IO_TYPE_21 = 2'd0,
   parameter logic [1:0] IO_TYPE_22 = 2'd0, parameter logic [1:0] IO_TYPE_23 = 2'd0,
   parameter logic [1:0] IO_TYPE_24 = 2'd0, parameter logic [1:0] IO_TYPE_25 = 2'd0,
   parameter logic [1:0] IO_TYPE_26 = 2'd0, parameter logic [1:0] IO_TYPE_27 = 2'd0,
   parameter logic [1:0] IO_TYPE_28 = 2'd0, parameter logic [1:0] IO_TYPE_29 = 2'd0,
   parameter logic [1:0] IO_TYPE_30 = 2'd0, parameter logic [1:0] IO_TYPE_31 = 2'd0,
   parameter logic [2:0] IO_INT_TYPE_0  = 3'd7, parameter logic [2:0] IO_INT_TYPE_1  = 3'd7,
   parameter logic [2:0] IO_INT_TYPE_2  = 3'd7, parameter logic [2:0] IO_INT_TYPE_3  = 3'd7,
   parameter logic [2:0] IO_INT_TYPE_4  = 3'd7, parameter logic [2:0] IO_INT_TYPE_5  = 3'd7,
   parameter logic [2:0] IO_INT_TYPE_6  = 3'd7, parameter logic [2:0] IO_INT_TYPE_7  = 3'd7,
   parameter logic [2:0] IO_INT_TYPE_8  = 3'd7, parameter logic [2:0] IO_INT_TYPE_9  = 3'd7,
   parameter logic [2:0] IO_INT_TYPE_10 = 3'd7, parameter logic [2:0] IO_INT_TYPE_11 = 3'd7,
   parameter logic [2:0] IO_INT_TYPE_12 = 3'd7, parameter logic [2:0] IO_INT_TYPE_13 = 3'd7,
   parameter logic [2:0] IO_INT_TYPE_14 = 3'd7, parameter logic [2:0] IO_INT_TYPE_15 = 3'd7,
   parameter logic [2:0] IO_INT_TYPE_16 = 3'd7, parameter logic [2:0] IO_INT_TYPE_17 = 3'd7,
   parameter logic [2:0] IO_INT_TYPE_18 = 3'd7, parameter logic [2:0] IO_INT_TYPE_19 = 3'd7,
   parameter logic [2:0] IO_INT_TYPE_20 = 3'd7, parameter logic [2:0] IO_INT_TYPE_21 = 3'd7,
   parameter logic [2:0] IO_INT_TYPE_22 = 3'd7, parameter logic [2:0] IO_INT_TYPE_23 = 3'd7,
   parameter logic [2:0] IO_INT_TYPE_24 = 3'd7, parameter logic [2:0] IO_INT_TYPE_25 = 3'd7,
   parameter logic [2:0] IO_INT_TYPE_26 = 3'd7, parameter logic [2:0] IO_INT_TYPE_27 = 3'd7,
   parameter logic [2:0] IO_INT_TYPE_28 = 3'd7, parameter logic [2:0] IO_INT_TYPE_29 = 3'd7,
   parameter logic [2:0] IO_INT_TYPE_30 = 3'd7, parameter logic [2:0] IO_INT_TYPE_31 = 3'd7
) (
   input  logic                 PCLK,
   input  logic                 PRESETN,
   input  logic                 PSEL,
   input  logic                 PENABLE,
   input  logic                 PWRITE,
   input  logic [7:0]           PADDR,
   input  logic [APB_WIDTH-1:0] PWDATA,
   output logic [APB_WIDTH-1:0] PRDATA,
   output logic                 PREADY,
   output logic                 PSLVERR,
   input  logic [IO_NUM-1:0]    GPIO_IN,
   output logic [IO_NUM-1:0]    GPIO_OUT,
   output logic [IO_NUM-1:0]    GPIO_OE,
   output logic [IO_NUM-1:0]    INT,
   output logic                 INT_OR
);

   // Number of APB-width lanes each 32-bit bank register is split into.
   localparam int LANES = 32 / APB_WIDTH;

   // Per-bit fixed-configuration parameters gathered into vectors so the
   // generate loop below can index them by bit number.
   localparam logic [31:0] FIXED_VEC = {
      FIXED_CONFIG_31, FIXED_CONFIG_30, FIXED_CONFIG_29, FIXED_CONFIG_28,
      FIXED_CONFIG_27, FIXED_CONFIG_26, FIXED_CONFIG_25, FIXED_CONFIG_24,
      FIXED_CONFIG_23, FIXED_CONFIG_22, FIXED_CONFIG_21, FIXED_CONFIG_20,
      FIXED_CONFIG_19, FIXED_CONFIG_18, FIXED_CONFIG_17, FIXED_CONFIG_16,
      FIXED_CONFIG_15, FIXED_CONFIG_14, FIXED_CONFIG_13, FIXED_CONFIG_12,
      FIXED_CONFIG_11, FIXED_CONFIG_10, FIXED_CONFIG_9,  FIXED_CONFIG_8,
      FIXED_CONFIG_7,  FIXED_CONFIG_6,  FIXED_CONFIG_5,  FIXED_CONFIG_4,
      FIXED_CONFIG_3,  FIXED_CONFIG_2,  FIXED_CONFIG_1,  FIXED_CONFIG_0};

   localparam logic [63:0] IOTYPE_VEC = {
      IO_TYPE_31, IO_TYPE_30, IO_TYPE_29, IO_TYPE_28, IO_TYPE_27, IO_TYPE_26,
      IO_TYPE_25, IO_TYPE_24, IO_TYPE_23, IO_TYPE_22, IO_TYPE_21, IO_TYPE_20,
      IO_TYPE_19, IO_TYPE_18, IO_TYPE_17, IO_TYPE_16, IO_TYPE_15, IO_TYPE_14,
      IO_TYPE_13, IO_TYPE_12, IO_TYPE_11, IO_TYPE_10, IO_TYPE_9,  IO_TYPE_8,
      IO_TYPE_7,  IO_TYPE_6,  IO_TYPE_5,  IO_TYPE_4,  IO_TYPE_3,  IO_TYPE_2,
      IO_TYPE_1,  IO_TYPE_0};

   localparam logic [95:0] ITYPE_VEC = {
      IO_INT_TYPE_31, IO_INT_TYPE_30, IO_INT_TYPE_29, IO_INT_TYPE_28,
      IO_INT_TYPE_27, IO_INT_TYPE_26, IO_INT_TYPE_25, IO_INT_TYPE_24,
      IO_INT_TYPE_23, IO_INT_TYPE_22, IO_INT_TYPE_21, IO_INT_TYPE_20,
      IO_INT_TYPE_19, IO_INT_TYPE_18, IO_INT_TYPE_17, IO_INT_TYPE_16,
      IO_INT_TYPE_15, IO_INT_TYPE_14, IO_INT_TYPE_13, IO_INT_TYPE_12,
      IO_INT_TYPE_11, IO_INT_TYPE_10, IO_INT_TYPE_9,  IO_INT_TYPE_8,
      IO_INT_TYPE_7,  IO_INT_TYPE_6,  IO_INT_TYPE_5,  IO_INT_TYPE_4,
      IO_INT_TYPE_3,  IO_INT_TYPE_2,  IO_INT_TYPE_1,  IO_INT_TYPE_0};

   logic [7:0]        cfg_q   [IO_NUM];
   logic [7:0]        cfg_d   [IO_NUM];
   logic [7:0]        cfg_eff [IO_NUM];
   logic [IO_NUM-1:0] sync1_q, sync2_q, prev_q;
   logic [IO_NUM-1:0] intr_q, intr_d;
   logic [IO_NUM-1:0] gpout_q, gpout_d;
   logic [IO_NUM-1:0] evt, gpin, lane_hit, lane_wdata;
   logic [IO_NUM-1:0] outreg_en, oe_en;

   logic       wr_en, cfg_hit, lane_ok, intr_hit, gpin_hit, gpout_hit;
   logic [4:0] cfg_idx;
   logic [1:0] lane_idx;
   logic [31:0] bank_rd, rd_shift;
   logic [7:0]  cfg_rd;

   assign wr_en    = PSEL & PENABLE & PWRITE;
   assign cfg_idx  = PADDR[6:2];
   assign lane_idx = PADDR[3:2];

   assign cfg_hit   = ~PADDR[7] & (PADDR[1:0] == 2'b00) & (int'(cfg_idx) < IO_NUM);
   assign lane_ok   = (PADDR[1:0] == 2'b00) & (int'(lane_idx) < LANES);
   assign intr_hit  = lane_ok & (PADDR[7:4] == 4'h8);
   assign gpin_hit  = lane_ok & (PADDR[7:4] == 4'h9);
   assign gpout_hit = lane_ok & (PADDR[7:4] == 4'hA);

   for (genvar g = 0; g < IO_NUM; g++) begin : g_bit
      localparam logic [2:0] FIX_ITYPE  = ITYPE_VEC[3*g +: 3];
      localparam logic [1:0] FIX_IOTYPE = IOTYPE_VEC[2*g +: 2];
      localparam logic [7:0] FIX_CFG    = {FIX_ITYPE, 1'b0, FIX_ITYPE != 3'd7,
                                           FIX_IOTYPE != 2'd0, FIX_IOTYPE != 2'd1,
                                           FIX_IOTYPE != 2'd0};
      logic raw_evt;

      // Fixed bits ignore the register entirely; the written value is kept
      // but never observed.
      assign cfg_eff[g]   = FIXED_VEC[g] ? FIX_CFG : cfg_q[g];
      assign outreg_en[g] = cfg_eff[g][0];
      assign gpin[g]      = sync2_q[g] & cfg_eff[g][1];
      assign oe_en[g]     = cfg_eff[g][2];

      // Which bank lane this bit lives in, and its write-data bit in that lane.
      assign lane_hit[g]   = (int'(lane_idx) == g / APB_WIDTH);
      assign lane_wdata[g] = PWDATA[g % APB_WIDTH];

      always_comb begin
         raw_evt = 1'b0;
         case (cfg_eff[g][7:5])
            3'd0:    raw_evt = sync2_q[g];
            3'd1:    raw_evt = ~sync2_q[g];
            3'd2:    raw_evt = sync2_q[g] & ~prev_q[g];
            3'd3:    raw_evt = ~sync2_q[g] & prev_q[g];
            3'd4:    raw_evt = sync2_q[g] ^ prev_q[g];
            default: raw_evt = 1'b0;
         endcase
      end

      assign evt[g] = raw_evt & cfg_eff[g][3] & cfg_eff[g][1];
   end

   always_comb begin
      intr_d  = intr_q;
      gpout_d = gpout_q;
      for (int n = 0; n < IO_NUM; n++) begin
         cfg_d[n] = cfg_q[n];
         if (wr_en && cfg_hit && (cfg_idx == 5'(n))) begin
            cfg_d[n] = {PWDATA[7:5], 1'b0, PWDATA[3:0]};
         end
      end
      if (wr_en && intr_hit) begin
         intr_d = intr_q & ~(lane_hit & lane_wdata);
      end
      // OR-ing events after the clear makes a simultaneous event win.
      intr_d = intr_d | evt;
      if (wr_en && gpout_hit) begin
         gpout_d = (gpout_q & ~lane_hit) | (lane_wdata & lane_hit);
      end
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         for (int n = 0; n < IO_NUM; n++) begin
            cfg_q[n] <= 8'h00;
         end
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         intr_q  <= '0;
         gpout_q <= IO_VAL;
      end else begin
         for (int n = 0; n < IO_NUM; n++) begin
            cfg_q[n] <= cfg_d[n];
         end
         sync1_q <= GPIO_IN;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         intr_q  <= intr_d;
         gpout_q <= gpout_d;
      end
   end

   always_comb begin
      bank_rd = 32'h0;
      if (intr_hit) begin
         bank_rd = 32'(intr_q);
      end else if (gpin_hit) begin
         bank_rd = 32'(gpin);
      end else if (gpout_hit) begin
         bank_rd = 32'(gpout_q);
      end
      rd_shift = bank_rd >> (int'(lane_idx) * APB_WIDTH);

      cfg_rd = 8'h00;
      for (int n = 0; n < IO_NUM; n++) begin
         if (cfg_idx == 5'(n)) begin
            cfg_rd = cfg_eff[n];
         end
      end

      PRDATA = '0;
      if (PSEL) begin
         if (cfg_hit) begin
            PRDATA[7:0] = cfg_rd;
         end else begin
            PRDATA = rd_shift[APB_WIDTH-1:0];
         end
      end
   end

   assign PREADY   = 1'b1;
   assign PSLVERR  = 1'b0;
   assign GPIO_OUT = gpout_q & outreg_en;
   // Both OE_TYPE settings drive the enable straight from configuration.
   assign GPIO_OE  = oe_en;
   assign INT      = (INT_BUS != 0) ? intr_q : '0;
   assign INT_OR   = |intr_q;

   logic unused_bits;
   assign unused_bits = &{1'b0, PWDATA, (OE_TYPE != 0)};

endmodule

// File: tb/tb_apb_gpio_core.sv
// tb/tb_apb_gpio_core.sv - directed testbench for apb_gpio_core
module tb_apb_gpio_core;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // 32-bit bus, 32 bits, default parameters
   logic        psel0, pen0, pwr0;
   logic [7:0]  addr0;
   logic [31:0] wdata0, rdata0;
   logic        ready0, err0;
   logic [31:0] gin0, gout0, goe0, int0;
   logic        intor0;

   // 8-bit bus, 16 bits, INT bus on, bit 1 fixed as output
   logic        psel1, pen1, pwr1;
   logic [7:0]  addr1;
   logic [7:0]  wdata1, rdata1;
   logic        ready1, err1;
   logic [15:0] gin1, gout1, goe1, int1;
   logic        intor1;

   int total = 0;
   int bad   = 0;
   logic [31:0] d;
   logic [7:0]  b;

   apb_gpio_core u_dut0 (
      .PCLK(clk), .PRESETN(rst_n), .PSEL(psel0), .PENABLE(pen0), .PWRITE(pwr0),
      .PADDR(addr0), .PWDATA(wdata0), .PRDATA(rdata0), .PREADY(ready0), .PSLVERR(err0),
      .GPIO_IN(gin0), .GPIO_OUT(gout0), .GPIO_OE(goe0), .INT(int0), .INT_OR(intor0)
   );

   apb_gpio_core #(
      .IO_NUM(16), .APB_WIDTH(8), .INT_BUS(1), .IO_VAL(16'h0002),
      .FIXED_CONFIG_1(1'b1), .IO_TYPE_1(2'd1)
   ) u_dut1 (
      .PCLK(clk), .PRESETN(rst_n), .PSEL(psel1), .PENABLE(pen1), .PWRITE(pwr1),
      .PADDR(addr1), .PWDATA(wdata1), .PRDATA(rdata1), .PREADY(ready1), .PSLVERR(err1),
      .GPIO_IN(gin1), .GPIO_OUT(gout1), .GPIO_OE(goe1), .INT(int1), .INT_OR(intor1)
   );

   task automatic wr0(input logic [7:0] a, input logic [31:0] v);
      @(negedge clk); psel0 = 1; pwr0 = 1; pen0 = 0; addr0 = a; wdata0 = v;
      @(negedge clk); pen0 = 1;
      @(negedge clk); psel0 = 0; pen0 = 0; pwr0 = 0;
   endtask

   task automatic rd0(input logic [7:0] a, output logic [31:0] v);
      psel0 = 1; pwr0 = 0; pen0 = 0; addr0 = a;
      #1 v = rdata0;
      psel0 = 0;
   endtask

   task automatic wr1(input logic [7:0] a, input logic [7:0] v);
      @(negedge clk); psel1 = 1; pwr1 = 1; pen1 = 0; addr1 = a; wdata1 = v;
      @(negedge clk); pen1 = 1;
      @(negedge clk); psel1 = 0; pen1 = 0; pwr1 = 0;
   endtask

   task automatic rd1(input logic [7:0] a, output logic [7:0] v);
      psel1 = 1; pwr1 = 0; pen1 = 0; addr1 = a;
      #1 v = rdata1;
      psel1 = 0;
   endtask

   task automatic test_reset;
      rst_n = 0;
      repeat (3) @(negedge clk);
      total++; if (gout0 !== 32'h0 || goe0 !== 32'h0) begin bad++; $display("FAIL rst_pads out=%h oe=%h exp=0", gout0, goe0); end
      total++; if (intor0 !== 1'b0 || int0 !== 32'h0) begin bad++; $display("FAIL rst_int or=%b int=%h exp=0", intor0, int0); end
      rst_n = 1;
      @(negedge clk);
      rd0(8'h00, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_cfg0 got=%h exp=0", d); end
      rd0(8'h80, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_intr got=%h exp=0", d); end
      rd0(8'h90, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_gpin got=%h exp=0", d); end
      rd0(8'hA0, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_gpout got=%h exp=0", d); end
      total++; if (ready0 !== 1'b1 || err0 !== 1'b0) begin bad++; $display("FAIL ready_err ready=%b err=%b exp=1/0", ready0, err0); end
      total++; if (gout1 !== 16'h0002 || goe1 !== 16'h0002) begin bad++; $display("FAIL rst_fixed out=%h oe=%h exp=0002", gout1, goe1); end
      rd1(8'hA0, b); total++; if (b !== 8'h02) begin bad++; $display("FAIL rst_ioval got=%h exp=02", b); end
   endtask

   task automatic test_output;
      wr0(8'h00, 32'h05);
      wr0(8'hA0, 32'h1);
      total++; if (gout0 !== 32'h1 || goe0 !== 32'h1) begin bad++; $display("FAIL out_bit0 out=%h oe=%h exp=1", gout0, goe0); end
      rd0(8'hA0, d); total++; if (d !== 32'h1) begin bad++; $display("FAIL out_rd got=%h exp=1", d); end
      wr0(8'hA0, 32'hFFFF_FFFF);
      total++; if (gout0 !== 32'h1) begin bad++; $display("FAIL out_gate got=%h exp=1", gout0); end
      rd0(8'hA0, d); total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL out_rdall got=%h exp=ffffffff", d); end
      wr0(8'hA0, 32'h0);
      wr0(8'h00, 32'h0);
   endtask

   task automatic test_input;
      wr0(8'h0C, 32'h02);
      gin0 = 32'h8;
      @(negedge clk);
      rd0(8'h90, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL in_lat1 got=%h exp=0", d); end
      @(negedge clk);
      rd0(8'h90, d); total++; if (d !== 32'h8) begin bad++; $display("FAIL in_lat2 got=%h exp=8", d); end
      rd0(8'h94, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL in_lane1 got=%h exp=0", d); end
      wr0(8'h0C, 32'hFF);
      rd0(8'h0C, d); total++; if (d !== 32'hEF) begin bad++; $display("FAIL cfg_bit4 got=%h exp=ef", d); end
      wr0(8'h0C, 32'h00);
      rd0(8'h90, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL in_gate got=%h exp=0", d); end
      rd0(8'hB0, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped got=%h exp=0", d); end
      gin0 = 32'h0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_edge_int;
      wr0(8'h14, 32'h4A);
      gin0[5] = 1'b1;
      repeat (2) @(negedge clk);
      rd0(8'h80, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL rise_early got=%h exp=0", d); end
      @(negedge clk);
      rd0(8'h80, d); total++; if (d !== 32'h20) begin bad++; $display("FAIL rise_set got=%h exp=20", d); end
      total++; if (intor0 !== 1'b1 || int0 !== 32'h0) begin bad++; $display("FAIL rise_pins or=%b int=%h exp=1/0", intor0, int0); end
      wr0(8'h80, 32'h20);
      rd0(8'h80, d); total++; if (d !== 32'h0 || intor0 !== 1'b0) begin bad++; $display("FAIL rise_clr got=%h or=%b exp=0", d, intor0); end
      repeat (5) @(negedge clk);
      rd0(8'h80, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL rise_hold got=%h exp=0", d); end
      wr0(8'h1C, 32'h6A);
      gin0[7] = 1'b1;
      repeat (4) @(negedge clk);
      rd0(8'h80, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL fall_on_rise got=%h exp=0", d); end
      gin0[7] = 1'b0;
      repeat (4) @(negedge clk);
      rd0(8'h80, d); total++; if (d !== 32'h80) begin bad++; $display("FAIL fall_set got=%h exp=80", d); end
      wr0(8'h80, 32'h0);
      rd0(8'h80, d); total++; if (d !== 32'h80) begin bad++; $display("FAIL w1c_zero got=%h exp=80", d); end
      wr0(8'h80, 32'hFFFF_FFFF);
      rd0(8'h80, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL w1c_all got=%h exp=0", d); end
      wr0(8'h20, 32'h48);
      gin0[8] = 1'b1;
      repeat (4) @(negedge clk);
      rd0(8'h80, d); total++; if (d !== 32'h0 || intor0 !== 1'b0) begin bad++; $display("FAIL no_inreg got=%h or=%b exp=0", d, intor0); end
      wr0(8'h14, 32'h0); wr0(8'h1C, 32'h0); wr0(8'h20, 32'h0);
      gin0 = 32'h0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_level_int;
      wr0(8'h08, 32'h0A);
      gin0[2] = 1'b1;
      repeat (3) @(negedge clk);
      rd0(8'h80, d); total++; if (d !== 32'h4) begin bad++; $display("FAIL lvl_hi_set got=%h exp=4", d); end
      wr0(8'h80, 32'h4);
      rd0(8'h80, d); total++; if (d !== 32'h4 || intor0 !== 1'b1) begin bad++; $display("FAIL lvl_hi_reassert got=%h or=%b exp=4/1", d, intor0); end
      gin0[2] = 1'b0;
      repeat (3) @(negedge clk);
      wr0(8'h80, 32'h4);
      rd0(8'h80, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL lvl_hi_clr got=%h exp=0", d); end
      wr0(8'h08, 32'h2A);
      @(negedge clk);
      rd0(8'h80, d); total++; if (d !== 32'h4) begin bad++; $display("FAIL lvl_lo_set got=%h exp=4", d); end
      wr0(8'h08, 32'h0);
      wr0(8'h80, 32'h4);
      rd0(8'h80, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL lvl_lo_clr got=%h exp=0", d); end
   endtask

   task automatic test_narrow_bus;
      wr1(8'h3C, 8'h01);
      wr1(8'hA4, 8'h80);
      total++; if (gout1 !== 16'h8002) begin bad++; $display("FAIL nb_out15 got=%h exp=8002", gout1); end
      rd1(8'hA4, b); total++; if (b !== 8'h80) begin bad++; $display("FAIL nb_rd_hi got=%h exp=80", b); end
      rd1(8'hA8, b); total++; if (b !== 8'h00) begin bad++; $display("FAIL nb_rd_lane2 got=%h exp=00", b); end
      wr1(8'hA0, 8'h00);
      total++; if (gout1 !== 16'h8000) begin bad++; $display("FAIL nb_lane_iso got=%h exp=8000", gout1); end
      rd1(8'h04, b); total++; if (b !== 8'hE5) begin bad++; $display("FAIL fixed_rd got=%h exp=e5", b); end
      wr1(8'h04, 8'h00);
      rd1(8'h04, b); total++; if (b !== 8'hE5) begin bad++; $display("FAIL fixed_wr got=%h exp=e5", b); end
      total++; if (goe1 !== 16'h0002) begin bad++; $display("FAIL fixed_oe got=%h exp=0002", goe1); end
      rd1(8'h40, b); total++; if (b !== 8'h00) begin bad++; $display("FAIL nb_cfg16 got=%h exp=00", b); end
      wr1(8'h24, 8'h4A);
      gin1 = 16'h0202;
      repeat (3) @(negedge clk);
      total++; if (int1 !== 16'h0200 || intor1 !== 1'b1) begin bad++; $display("FAIL nb_int got=%h or=%b exp=0200/1", int1, intor1); end
      rd1(8'h84, b); total++; if (b !== 8'h02) begin bad++; $display("FAIL nb_intr_hi got=%h exp=02", b); end
      rd1(8'h90, b); total++; if (b !== 8'h00) begin bad++; $display("FAIL nb_gpin_lo got=%h exp=00", b); end
      rd1(8'h94, b); total++; if (b !== 8'h02) begin bad++; $display("FAIL nb_gpin_hi got=%h exp=02", b); end
      wr1(8'h84, 8'h02);
      total++; if (int1 !== 16'h0 || intor1 !== 1'b0) begin bad++; $display("FAIL nb_clr got=%h or=%b exp=0", int1, intor1); end
   endtask

   initial begin
      psel0 = 0; pen0 = 0; pwr0 = 0; addr0 = 0; wdata0 = 0; gin0 = 0;
      psel1 = 0; pen1 = 0; pwr1 = 0; addr1 = 0; wdata1 = 0; gin1 = 0;
      test_reset;
      test_output;
      test_input;
      test_edge_int;
      test_level_int;
      test_narrow_bus;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/apb_gpio_core.md
Name: apb_gpio_core

Overview:
- APB slave GPIO controller with up to 32 I/O bits, each with its own 8-bit configuration register.
- Per-bit input capture, output drive, output-enable, and edge- or level-sensitive interrupt generation, including a combined OR interrupt.
- Sits on a peripheral APB bus; GPIO_IN, GPIO_OUT and GPIO_OE connect to pad logic at the top level.

Parameters:
- IO_NUM, 32, number of implemented GPIO bits (1..32).
- APB_WIDTH, 32, APB data width (8, 16 or 32).
- OE_TYPE, 0, 0 = GPIO_OE driven from configuration; 1 = identical behaviour (reserved for internal tristate).
- INT_BUS, 0, 1 = INT[] carries per-bit interrupts; 0 = INT[] held at 0. INT_OR is always active.
- IO_VAL, 0, reset value of the GPOUT register (IO_NUM bits).
- FIXED_CONFIG_0..31, 0, 1 = bit n's configuration is fixed by parameters and writes to CONFIG_n are ignored.
- IO_TYPE_0..31, 0, fixed-mode direction: 0 input, 1 output, 2 bidirectional.
- IO_INT_TYPE_0..31, 7, fixed-mode interrupt type: 0..4 per the INT_TYPE encoding below; 7 = no interrupt.

Ports:
- PCLK  in  1  APB clock; the only clock.
- PRESETN  in  1  asynchronous active-low reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  APB write strobe.
- PADDR  in  8  byte address.
- PWDATA  in  APB_WIDTH  write data.
- PRDATA  out  APB_WIDTH  read data.
- PREADY  out  1  tied to 1.
- PSLVERR  out  1  tied to 0.
- GPIO_IN  in  IO_NUM  pad inputs (asynchronous).
- GPIO_OUT  out  IO_NUM  output values.
- GPIO_OE  out  IO_NUM  per-bit output enables.
- INT  out  IO_NUM  per-bit interrupt flags.
- INT_OR  out  1  OR of all interrupt flags.

Behaviour:
- Write strobe: PSEL & PENABLE & PWRITE, sampled at the rising edge of PCLK. Zero wait states.
- Reads: PRDATA is combinational from PADDR and is valid whenever PSEL=1. Unmapped addresses read 0. Only bits [7:0] are used for CONFIG reads; upper bits read 0.
- CONFIG_n register: located at 0x00 + 4n for n < IO_NUM. 8 bits, reset value 0.
  - bit0 OUTREG_EN: when 0, GPIO_OUT[n] is forced to 0.
  - bit1 INREG_EN: when 0, GPIN[n] reads 0 and the bit raises no interrupt.
  - bit2 OUTBUF_EN: drives GPIO_OE[n].
  - bit3 INT_EN.
  - bit4 unused, reads 0.
  - bits[7:5] INT_TYPE: 0 level-high, 1 level-low, 2 rising edge, 3 falling edge, 4 both edges; 5..7 no interrupt.
- Fixed configuration (FIXED_CONFIG_n=1): reads return {INT_TYPE=IO_INT_TYPE_n, 0, INT_EN=(IO_INT_TYPE_n!=7), OUTBUF_EN=(IO_TYPE_n!=0), INREG_EN=(IO_TYPE_n!=1), OUTREG_EN=(IO_TYPE_n!=0)}. Writes are ignored.
- Bank registers, each IO_NUM bits wide, split into APB_WIDTH-sized lanes at 4-byte stride:
  - INTR base 0x80: read shows status; writing 1 clears the bit (W1C).
  - GPIN base 0x90: read-only.
  - GPOUT base 0xA0: read/write, reset value IO_VAL.
  - Lanes per width: 32-bit uses base only; 16-bit uses base (bits 15:0) and base+4 (31:16); 8-bit uses base, +4, +8, +0xC.
- Input path: GPIO_IN passes through a 2-flop synchronizer (sync2). A third flop (prev) holds the previous sync2 value for edge detection.
  - GPIN[n] = sync2[n] & INREG_EN[n].
  - Input latency: a GPIO_IN change is visible in GPIN after 2 PCLK edges.
- Interrupt event per bit (requires INT_EN & INREG_EN):
  - Level-high: sync2=1.
  - Level-low: sync2=0.
  - Rising edge: sync2 & ~prev.
  - Falling edge: ~sync2 & prev.
  - Both edges: sync2 ^ prev.
- Interrupt flag: the event sets INTR[n] on the next edge. The flag stays set until cleared by a W1C write.
  - An event in the same cycle as a W1C clear: set wins.
  - A level interrupt re-asserts immediately while the condition holds.
- INT[n] = INTR[n] when INT_BUS=1, else 0. INT_OR = |INTR[IO_NUM-1:0].
- Reset (async, PRESETN=0): all CONFIG=0, INTR=0, sync/prev flops=0, GPOUT=IO_VAL. Consequently GPIO_OUT=0, GPIO_OE=0, INT=0, INT_OR=0.

Test Plan:
- Reset, then read 0x00, 0x80, 0x90 and 0xA0 -> all read 0; GPIO_OE=0 and GPIO_OUT=0.
- Write CONFIG_0=0x05, write GPOUT=0x1 -> GPIO_OUT[0]=1 and GPIO_OE[0]=1; reading 0xA0 returns 0x1.
- Write CONFIG_3=0x02, drive GPIO_IN[3]=1 -> after 2 PCLK edges GPIN reads 0x8; with CONFIG_3=0x00, GPIN reads 0.
- Write CONFIG_5=0x4A (rising edge, INT_EN, INREG_EN), pulse GPIO_IN[5] 0->1 -> INTR=0x20 and INT_OR=1. Write 0x20 to 0x80 -> INTR=0 and INT_OR=0. Holding GPIO_IN[5] high does not re-set the flag.
- Level-high interrupt on bit 2 with the input held at 1 -> a W1C write does not keep INTR[2] clear; it re-sets on the next edge.
- APB_WIDTH=8, IO_NUM=16: write 0xA4=0x80 -> GPIO_OUT[15]=1. With FIXED_CONFIG_1=1 and IO_TYPE_1=1, CONFIG_1 reads 0xE5 and writes to it are ignored.
